// File: rtl/servo_pkg.sv
// Shared types, default timing constants and the angle-to-pulse mapping
// for the servo bank.
package servo_pkg;
  typedef logic [7:0] angle_t;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_FRAME_CYC  = 1_000_000;
  localparam int DEF_MIN_CYC    = 25_000;
  localparam int DEF_MAX_CYC    = 125_000;
  localparam int DEF_MAX_ANGLE  = 180;
  localparam int DEF_HOME_ANGLE = 90;
  localparam int DEF_TICK_CYC   = 1_000_000;
  localparam int DEF_SLEW       = 2;

  // Multiply before dividing, at 64 bits, so no precision is lost on the way
  function automatic logic [31:0] angle_to_pulse(input angle_t angle, input int min_cyc,
                                                 input int max_cyc, input int max_angle);
    logic [63:0] scaled;
    scaled = 64'(max_cyc - min_cyc) * 64'(angle);
    return 32'(64'(min_cyc) + scaled / 64'(max_angle));
  endfunction
endpackage

// File: rtl/servo_ch.sv
// One servo channel: target/actual angle registers, slew limiting,
// frame-aligned pulse width latch and PWM comparator.
module servo_ch
  import servo_pkg::*;
#(
  parameter int FRAME_W    = 20,
  parameter int MIN_CYC    = DEF_MIN_CYC,
  parameter int MAX_CYC    = DEF_MAX_CYC,
  parameter int MAX_ANGLE  = DEF_MAX_ANGLE,
  parameter int HOME_ANGLE = DEF_HOME_ANGLE,
  parameter int SLEW       = DEF_SLEW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [FRAME_W-1:0] frame_cnt,
  input  logic               inc_req,
  input  logic               dec_req,
  input  logic [2:0]         step,
  input  logic               abs_load,
  input  angle_t             abs_value,
  output logic               pwm,
  output angle_t             actual,
  output logic               busy
);
  localparam int PW = $clog2(MAX_CYC + 1);
  localparam logic [PW-1:0] HOME_PULSE =
    PW'(angle_to_pulse(angle_t'(HOME_ANGLE), MIN_CYC, MAX_CYC, MAX_ANGLE));

  angle_t        target_q;
  angle_t        target_d;
  angle_t        actual_d;
  logic [PW-1:0] pulse_q;
  logic [PW-1:0] pulse_now;
  logic [PW-1:0] pulse_use;
  logic          frame_start;

  // The width used at frame count 0 is the freshly latched one, so no runt pulse
  assign frame_start = (frame_cnt == '0);
  assign pulse_now   = PW'(angle_to_pulse(actual, MIN_CYC, MAX_CYC, MAX_ANGLE));
  assign pulse_use   = frame_start ? pulse_now : pulse_q;

  always_comb begin
    int step_eff;
    int sum;
    int gap;
    int move;
    target_d = target_q;
    actual_d = actual;
    step_eff = (step == 3'd0) ? 1 : int'(step);
    sum      = int'(target_q) + step_eff;
    gap      = int'(target_q) - int'(actual);
    move     = (gap < 0) ? -gap : gap;
    if (move > SLEW) move = SLEW;
    if (tick) begin
      if (inc_req)
        target_d = (sum > MAX_ANGLE) ? angle_t'(MAX_ANGLE) : angle_t'(sum);
      else if (dec_req)
        target_d = (int'(target_q) < step_eff) ? '0 : angle_t'(int'(target_q) - step_eff);
      if (gap > 0)      actual_d = angle_t'(int'(actual) + move);
      else if (gap < 0) actual_d = angle_t'(int'(actual) - move);
    end
    // An absolute set overrides a same-cycle inc/dec
    if (abs_load) target_d = abs_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= angle_t'(HOME_ANGLE);
      actual   <= angle_t'(HOME_ANGLE);
      pulse_q  <= HOME_PULSE;
      pwm      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      target_q <= target_d;
      actual   <= actual_d;
      busy     <= (actual != target_q);
      if (frame_start) pulse_q <= pulse_now;
      pwm      <= (32'(frame_cnt) < 32'(pulse_use));
    end
  end
endmodule

// File: rtl/servo_bank.sv
// Multi-channel hobby-servo driver: shared update tick and PWM frame
// counters, inc/dec and absolute-set target control, slew-limited motion.
module servo_bank
  import servo_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int FRAME_CYC  = DEF_FRAME_CYC,
  parameter int MIN_CYC    = DEF_MIN_CYC,
  parameter int MAX_CYC    = DEF_MAX_CYC,
  parameter int MAX_ANGLE  = DEF_MAX_ANGLE,
  parameter int HOME_ANGLE = DEF_HOME_ANGLE,
  parameter int TICK_CYC   = DEF_TICK_CYC,
  parameter int SLEW       = DEF_SLEW
) (
  input  logic                                         CLOCK_50,
  input  logic                                         reset,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
  input  logic                                         inc,
  input  logic                                         dec,
  input  logic [2:0]                                   step,
  input  logic                                         abs_valid,
  input  logic [3:0]                                   abs_ch,
  input  logic [7:0]                                   abs_angle,
  output logic                                         abs_ready,
  output logic                                         abs_err,
  output logic [NUM_CH-1:0]                            pwm,
  output logic [8*NUM_CH-1:0]                          angle_bus,
  output logic [NUM_CH-1:0]                            busy
);
  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int FW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;

  if (NUM_CH < 1 || NUM_CH > 16 || CLK_HZ <= 0 || MAX_ANGLE < 1 || MAX_ANGLE > 255 ||
      HOME_ANGLE > MAX_ANGLE || MAX_CYC < MIN_CYC) begin : g_bad_params
    $error("servo_bank: parameter out of range");
  end

  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] frame_cnt;
  logic          tick;
  logic          hs;
  logic          sel_ok;
  logic          inc_only;
  logic          dec_only;
  angle_t        abs_value;

  assign tick      = (tick_cnt == TW'(TICK_CYC - 1));
  assign hs        = abs_valid & abs_ready;
  assign sel_ok    = (32'(sel) < 32'(NUM_CH));
  assign inc_only  = inc & ~dec & sel_ok;
  assign dec_only  = dec & ~inc & sel_ok;
  assign abs_value = (32'(abs_angle) > 32'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : abs_angle;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      frame_cnt <= '0;
      abs_ready <= 1'b0;
      abs_err   <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      frame_cnt <= (frame_cnt == FW'(FRAME_CYC - 1)) ? '0 : frame_cnt + 1'b1;
      abs_ready <= 1'b1;
      abs_err   <= hs & (32'(abs_ch) >= 32'(NUM_CH));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_ch #(
      .FRAME_W    (FW),
      .MIN_CYC    (MIN_CYC),
      .MAX_CYC    (MAX_CYC),
      .MAX_ANGLE  (MAX_ANGLE),
      .HOME_ANGLE (HOME_ANGLE),
      .SLEW       (SLEW)
    ) u_ch (
      .clk       (CLOCK_50),
      .rst       (reset),
      .tick      (tick),
      .frame_cnt (frame_cnt),
      .inc_req   (inc_only & (32'(sel) == 32'(i))),
      .dec_req   (dec_only & (32'(sel) == 32'(i))),
      .step      (step),
      .abs_load  (hs & (32'(abs_ch) == 32'(i))),
      .abs_value (abs_value),
      .pwm       (pwm[i]),
      .actual    (angle_bus[8*i +: 8]),
      .busy      (busy[i])
    );
  end
endmodule

// File: tb/tb_servo_bank.sv
// Self-checking bench for servo_bank: directed scenarios plus randomized
// traffic, checked against a cycle-indexed behavioural model.
module tb_servo_bank;
  localparam int NCH = 3, TICK = 10, FRAME = 200, MINC = 20, MAXC = 110;
  localparam int MAXA = 180, HOME = 90, SLEW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = '0;
  logic        inc = 1'b0, dec = 1'b0;
  logic [2:0]  step = '0;
  logic        abs_valid = 1'b0;
  logic [3:0]  abs_ch = '0;
  logic [7:0]  abs_angle = '0;
  logic        abs_ready, abs_err;
  logic [2:0]  pwm, busy;
  logic [23:0] angle_bus;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  servo_bank #(
    .NUM_CH(NCH), .FRAME_CYC(FRAME), .MIN_CYC(MINC), .MAX_CYC(MAXC),
    .MAX_ANGLE(MAXA), .HOME_ANGLE(HOME), .TICK_CYC(TICK), .SLEW(SLEW)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .sel(sel), .inc(inc), .dec(dec), .step(step),
    .abs_valid(abs_valid), .abs_ch(abs_ch), .abs_angle(abs_angle),
    .abs_ready(abs_ready), .abs_err(abs_err), .pwm(pwm), .angle_bus(angle_bus), .busy(busy)
  );

  // Reference model indexed by the number of clock edges since reset release
  int       m_tgt[NCH], m_act[NCH], m_pulse[NCH];
  int       m_n;
  logic [2:0] m_pwm, m_busy;
  logic     m_ready, m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_tgt[i] = HOME; m_act[i] = HOME; m_pulse[i] = MINC + HOME * (MAXC - MINC) / MAXA;
      end
      m_n = 0; m_pwm = '0; m_busy = '0; m_ready = 1'b0; m_err = 1'b0;
    end else begin
      bit tk, hs;
      int fpos, st, diff, s;
      int ot[NCH], oa[NCH];
      tk = (m_n % TICK) == TICK - 1;
      fpos = m_n % FRAME;
      ot = m_tgt; oa = m_act;
      st = (step == 0) ? 1 : int'(step);
      s = int'(sel);
      hs = m_ready && abs_valid;
      for (int i = 0; i < NCH; i++) begin
        m_busy[i] = (oa[i] != ot[i]);
        if (fpos == 0) m_pulse[i] = MINC + oa[i] * (MAXC - MINC) / MAXA;
        m_pwm[i] = (fpos < m_pulse[i]);
        if (tk) begin
          diff = ot[i] - oa[i];
          if (diff > 0)      m_act[i] = oa[i] + ((diff < SLEW) ? diff : SLEW);
          else if (diff < 0) m_act[i] = oa[i] - ((-diff < SLEW) ? -diff : SLEW);
        end
      end
      if (tk && s < NCH && inc && !dec) m_tgt[s] = (ot[s] + st > MAXA) ? MAXA : ot[s] + st;
      if (tk && s < NCH && dec && !inc) m_tgt[s] = (ot[s] - st < 0) ? 0 : ot[s] - st;
      if (hs && int'(abs_ch) < NCH)
        m_tgt[int'(abs_ch)] = (int'(abs_angle) > MAXA) ? MAXA : int'(abs_angle);
      m_err = hs && int'(abs_ch) >= NCH;
      m_ready = 1'b1;
      m_n++;
    end
  end

  function automatic logic [29:0] exp_vec();
    return {8'(m_act[2]), 8'(m_act[1]), 8'(m_act[0]), m_busy, m_pwm};
  endfunction

  task automatic applyStimulus(input logic [1:0] s, input logic i, input logic d,
                               input logic [2:0] stp, input logic av,
                               input logic [3:0] ch, input logic [7:0] ang);
    sel = s; inc = i; dec = d; step = stp; abs_valid = av; abs_ch = ch; abs_angle = ang;
  endtask

  task automatic idle();
    applyStimulus(2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic wait_phase(input int modv, input int ph);
    for (int k = 0; k <= modv && (m_n % modv) != ph; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    int hi[NCH];
    reset = 1'b1; idle();
    repeat (3) @(negedge clk);
    checks++;
    if ({abs_ready, abs_err, pwm, busy} !== 8'b0) begin
      fails++; $display("[TB] FAIL reset_outputs: got %b expected %b", {abs_ready, abs_err, pwm, busy}, 8'b0);
    end
    checks++;
    if (angle_bus !== {3{8'd90}}) begin
      fails++; $display("[TB] FAIL reset_angles: got %h expected %h", angle_bus, {3{8'd90}});
    end
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    repeat (FRAME) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm[i]);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (hi[i] != 65) begin
        fails++; $display("[TB] FAIL home_width ch%0d: got %0d expected 65", i, hi[i]);
      end
    end
    checks++;
    if ({abs_ready, angle_bus, busy, pwm} !== {1'b1, exp_vec()}) begin
      fails++; $display("[TB] FAIL post_reset_state: got %h expected %h", {abs_ready, angle_bus, busy, pwm}, {1'b1, exp_vec()});
    end
  endtask

  task automatic test_slew();
    int q[$], expq[$];
    int prev, v;
    bit same;
    wait_phase(TICK, 0);
    applyStimulus(2'd1, 1'b1, 1'b0, 3'd5, 1'b0, 4'd0, 8'd0);
    prev = HOME;
    for (int k = 0; k < 400; k++) begin
      if (k == 30) idle();
      @(negedge clk);
      if (int'(angle_bus[15:8]) != prev) begin prev = int'(angle_bus[15:8]); q.push_back(prev); end
      if (k > 40 && busy[1] == 1'b0) break;
    end
    v = HOME;
    while (v != 105) begin v += ((105 - v) < SLEW) ? (105 - v) : SLEW; expq.push_back(v); end
    same = (q.size() == expq.size());
    if (same) foreach (expq[i]) if (q[i] != expq[i]) same = 1'b0;
    checks++;
    if (!same) begin
      fails++; $display("[TB] FAIL slew_sequence: got %0d steps ending %0d expected %0d steps ending 105", q.size(), prev, expq.size());
    end
    checks++;
    if ({angle_bus[15:8], busy[1]} !== {8'd105, 1'b0}) begin
      fails++; $display("[TB] FAIL slew_final: got angle %0d busy %b expected 105 busy 0", angle_bus[15:8], busy[1]);
    end
    checks++;
    if ({angle_bus, busy, pwm} !== exp_vec()) begin
      fails++; $display("[TB] FAIL slew_model: got %h expected %h", {angle_bus, busy, pwm}, exp_vec());
    end
  endtask

  task automatic test_clamp();
    applyStimulus(2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 8'd250);
    @(negedge clk); applyStimulus(2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2, 8'd178);
    @(negedge clk); idle();
    wait_phase(TICK, 9);
    applyStimulus(2'd2, 1'b1, 1'b0, 3'd7, 1'b0, 4'd0, 8'd0);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 1500 && (busy[0] || busy[2]); k++) @(negedge clk);
    checks++;
    if ({angle_bus[23:16], angle_bus[7:0]} !== {8'd180, 8'd180}) begin
      fails++; $display("[TB] FAIL clamp_high: got ch0 %0d ch2 %0d expected 180 180", angle_bus[7:0], angle_bus[23:16]);
    end
    applyStimulus(2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2, 8'd3);
    @(negedge clk); idle();
    wait_phase(TICK, 9);
    applyStimulus(2'd2, 1'b0, 1'b1, 3'd7, 1'b0, 4'd0, 8'd0);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 1500 && busy[2]; k++) @(negedge clk);
    checks++;
    if ({angle_bus[23:16], busy[2]} !== {8'd0, 1'b0}) begin
      fails++; $display("[TB] FAIL clamp_low: got ch2 %0d busy %b expected 0 busy 0", angle_bus[23:16], busy[2]);
    end
    checks++;
    if ({angle_bus, busy, pwm} !== exp_vec()) begin
      fails++; $display("[TB] FAIL clamp_model: got %h expected %h", {angle_bus, busy, pwm}, exp_vec());
    end
  endtask

  task automatic test_abs_tick();
    int errs;
    wait_phase(TICK, 9);
    applyStimulus(2'd1, 1'b1, 1'b0, 3'd7, 1'b1, 4'd1, 8'd10);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 1000 && busy[1]; k++) @(negedge clk);
    checks++;
    if (angle_bus[15:8] !== 8'd10) begin
      fails++; $display("[TB] FAIL abs_wins: got ch1 %0d expected 10", angle_bus[15:8]);
    end
    applyStimulus(2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd5, 8'd50);
    errs = 0;
    @(negedge clk); errs += int'(abs_err); idle();
    repeat (30) begin @(negedge clk); errs += int'(abs_err); end
    checks++;
    if (errs != 1) begin
      fails++; $display("[TB] FAIL abs_err_pulse: got %0d pulses expected 1", errs);
    end
    checks++;
    if ({angle_bus, busy} !== {8'd0, 8'd10, 8'd180, 3'b000}) begin
      fails++; $display("[TB] FAIL abs_err_nochange: got %h expected %h", {angle_bus, busy}, {8'd0, 8'd10, 8'd180, 3'b000});
    end
  endtask

  task automatic test_midframe();
    int w1, w2, exp2;
    wait_phase(FRAME, 0);
    w1 = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 50) applyStimulus(2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 8'd0);
      if (k == 51) idle();
      @(negedge clk);
      w1 += int'(pwm[0]);
    end
    w2 = 0;
    repeat (FRAME) begin @(negedge clk); w2 += int'(pwm[0]); end
    exp2 = MINC + (MAXA - SLEW * 15) * (MAXC - MINC) / MAXA;
    checks++;
    if (w1 != MAXC) begin
      fails++; $display("[TB] FAIL midframe_width: got %0d expected %0d", w1, MAXC);
    end
    checks++;
    if (w2 != exp2) begin
      fails++; $display("[TB] FAIL next_frame_width: got %0d expected %0d", w2, exp2);
    end
  endtask

  task automatic test_reset_midframe();
    wait_phase(FRAME, 30);
    checks++;
    if (pwm[0] !== 1'b1) begin
      fails++; $display("[TB] FAIL pre_reset_pwm: got %b expected 1", pwm[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (pwm !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_truncate: got %b expected 000", pwm);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (pwm !== 3'b000) begin
      fails++; $display("[TB] FAIL release_pwm: got %b expected 000", pwm);
    end
    @(negedge clk);
    checks++;
    if ({pwm, angle_bus} !== {3'b111, {3{8'd90}}}) begin
      fails++; $display("[TB] FAIL first_rise: got %h expected %h", {pwm, angle_bus}, {3'b111, {3{8'd90}}});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++;
      if ({angle_bus, busy, pwm} !== exp_vec()) begin
        fails++; $display("[TB] FAIL random_state cycle %0d: got %h expected %h", k, {angle_bus, busy, pwm}, exp_vec());
      end
      checks++;
      if ({abs_ready, abs_err} !== {m_ready, m_err}) begin
        fails++; $display("[TB] FAIL random_abs cycle %0d: got %b expected %b", k, {abs_ready, abs_err}, {m_ready, m_err});
      end
      applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                    4'($urandom_range(0, 5)), 8'($urandom));
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_slew();
    test_clamp();
    test_abs_tick();
    test_midframe();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
